// File: rtl/uart_pkg.sv
// uart_pkg: shared types and constants for the oversampling UART blocks.
//   rx_state_e    - receiver frame state
//   parity_mode_e - parity setting latched for one frame
//   OS_8 / OS_16  - the oversample ratios the receiver supports
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_START     = 3'd1,
    ST_DATA      = 3'd2,
    ST_PARITY    = 3'd3,
    ST_STOP1     = 3'd4,
    ST_STOP2     = 3'd5,
    ST_WAIT_HIGH = 3'd6
  } rx_state_e;

  typedef enum logic [1:0] {
    PAR_NONE = 2'd0,
    PAR_EVEN = 2'd1,
    PAR_ODD  = 2'd2
  } parity_mode_e;

  localparam int OS_8  = 8;
  localparam int OS_16 = 16;

  function automatic logic os_legal(input int os);
    return (os == OS_8) || (os == OS_16);
  endfunction

  function automatic parity_mode_e parity_mode(input logic en, input logic odd);
    if (!en) return PAR_NONE;
    return odd ? PAR_ODD : PAR_EVEN;
  endfunction

endpackage

// File: rtl/uart_rx_os_if.sv
// uart_rx_os_if: received-word output bus of the UART receiver.
//   rx_valid / rx_ready - valid/ready handshake for one held frame
//   RX_data_out         - received word
//   parity_bit_err      - parity mismatch of the held frame
//   stop_bit_err        - low stop sample in the held frame
//   overrun_err         - one-cycle pulse when a frame is dropped
// master = receiver side, slave = consumer side.
interface uart_rx_os_if #(parameter int WIDTH = 8);
  logic             rx_valid;
  logic             rx_ready;
  logic [WIDTH-1:0] RX_data_out;
  logic             parity_bit_err;
  logic             stop_bit_err;
  logic             overrun_err;

  modport master (
    output rx_valid, RX_data_out, parity_bit_err, stop_bit_err, overrun_err,
    input  rx_ready
  );

  modport slave (
    input  rx_valid, RX_data_out, parity_bit_err, stop_bit_err, overrun_err,
    output rx_ready
  );
endinterface

// File: rtl/uart_baud_tick.sv
// uart_baud_tick: oversample tick generator shared by the UART rx/tx.
//   clk, rst - system clock, async active-high reset
//   clr      - restart the count (phase alignment), suppresses tick
//   div      - clocks per tick minus 1
//   tick     - one-clock pulse at terminal count
module uart_baud_tick #(
  parameter int DIV_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic [DIV_W-1:0] div,
  output logic             tick
);

  logic [DIV_W-1:0] cnt_q, cnt_d;

  // >= keeps the counter from running away if div shrinks while idle
  always_comb begin
    tick  = !clr && (cnt_q >= div);
    cnt_d = cnt_q + DIV_W'(1);
    if (clr || tick) cnt_d = '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

endmodule

// File: rtl/uart_rx_os.sv
// uart_rx_os: oversampling UART receiver with mid-bit sampling.
//   clk, rst             - system clock, async active-high reset
//   baud_div             - clocks per oversample tick minus 1
//   parity_en/parity_odd - parity mode, latched at start confirmation
//   two_stop             - two stop bits, latched at start confirmation
//   RX_data              - asynchronous serial input, idle high
//   rx_if                - held-frame output bus (master side)
//
// state     | meaning
// IDLE      | line idle, waiting for a synchronised falling edge
// START     | half-bit wait, then confirm start bit still low
// DATA      | sample WIDTH data bits at mid-bit, LSB first
// PARITY    | sample and check the parity bit
// STOP1     | sample first stop bit
// STOP2     | sample second stop bit
// WAIT_HIGH | final stop was low (break), wait for line to go high
module uart_rx_os
  import uart_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int OS    = 16,
  parameter int DIV_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [DIV_W-1:0] baud_div,
  input  logic             parity_en,
  input  logic             parity_odd,
  input  logic             two_stop,
  input  logic             RX_data,
  uart_rx_os_if.master     rx_if
);

  if (!os_legal(OS)) begin : g_bad_os
    $error("uart_rx_os: OS must be 8 or 16");
  end

  localparam int OS_W  = $clog2(OS);
  localparam int BIT_W = $clog2(WIDTH);
  localparam logic [OS_W-1:0]  OS_LAST  = OS_W'(OS - 1);
  localparam logic [OS_W-1:0]  OS_HALF  = OS_W'(OS / 2 - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(WIDTH - 1);

  logic rx_s1_q, rx_s2_q, rx_prev_q, rx_fall;
  logic tick, tick_clr, sample, frame_done;

  rx_state_e        state_q, state_d;
  logic [OS_W-1:0]  os_cnt_q, os_cnt_d;
  logic [BIT_W-1:0] bit_cnt_q, bit_cnt_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  parity_mode_e     mode_q, mode_d;
  logic             stop2_q, stop2_d;
  logic             par_err_q, par_err_d;
  logic             stop_err_q, stop_err_d;

  logic [WIDTH-1:0] data_out_q, data_out_d;
  logic             perr_out_q, perr_out_d;
  logic             serr_out_q, serr_out_d;
  logic             valid_q, valid_d;
  logic             ovr_q, ovr_d;

  assign rx_fall = rx_prev_q & ~rx_s2_q;

  uart_baud_tick #(.DIV_W(DIV_W)) u_tick (
    .clk  (clk),
    .rst  (rst),
    .clr  (tick_clr),
    .div  (baud_div),
    .tick (tick)
  );

  // os_cnt wraps naturally at OS, so mid-bit samples fall every OS ticks
  // once START has re-zeroed it at the start-bit centre.
  assign sample = tick && (os_cnt_q == OS_LAST);

  always_comb begin
    state_d    = state_q;
    os_cnt_d   = tick ? os_cnt_q + OS_W'(1) : os_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    mode_d     = mode_q;
    stop2_d    = stop2_q;
    par_err_d  = par_err_q;
    stop_err_d = stop_err_q;
    tick_clr   = 1'b0;
    frame_done = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (rx_fall) begin
          state_d  = ST_START;
          tick_clr = 1'b1;
          os_cnt_d = '0;
        end
      end
      ST_START: begin
        if (tick && (os_cnt_q == OS_HALF)) begin
          os_cnt_d = '0;
          if (!rx_s2_q) begin
            state_d    = ST_DATA;
            bit_cnt_d  = '0;
            mode_d     = parity_mode(parity_en, parity_odd);
            stop2_d    = two_stop;
            par_err_d  = 1'b0;
            stop_err_d = 1'b0;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      ST_DATA: begin
        if (sample) begin
          shift_d   = {rx_s2_q, shift_q[WIDTH-1:1]};
          bit_cnt_d = bit_cnt_q + BIT_W'(1);
          if (bit_cnt_q == BIT_LAST)
            state_d = (mode_q != PAR_NONE) ? ST_PARITY : ST_STOP1;
        end
      end
      ST_PARITY: begin
        if (sample) begin
          par_err_d = rx_s2_q ^ (^shift_q) ^ (mode_q == PAR_ODD);
          state_d   = ST_STOP1;
        end
      end
      ST_STOP1, ST_STOP2: begin
        if (sample) begin
          stop_err_d = stop_err_q | ~rx_s2_q;
          if ((state_q == ST_STOP1) && stop2_q) begin
            state_d = ST_STOP2;
          end else begin
            frame_done = 1'b1;
            state_d    = rx_s2_q ? ST_IDLE : ST_WAIT_HIGH;
          end
        end
      end
      ST_WAIT_HIGH: begin
        if (rx_s2_q) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // A completing frame loads only if the register is free or being drained
  // in the same cycle; otherwise it is dropped and flagged as overrun.
  always_comb begin
    data_out_d = data_out_q;
    perr_out_d = perr_out_q;
    serr_out_d = serr_out_q;
    valid_d    = valid_q;
    ovr_d      = 1'b0;
    if (valid_q && rx_if.rx_ready) valid_d = 1'b0;
    if (frame_done) begin
      if (!valid_q || rx_if.rx_ready) begin
        data_out_d = shift_q;
        perr_out_d = par_err_q;
        serr_out_d = stop_err_d;
        valid_d    = 1'b1;
      end else begin
        ovr_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_s1_q    <= 1'b1;
      rx_s2_q    <= 1'b1;
      rx_prev_q  <= 1'b1;
      state_q    <= ST_IDLE;
      os_cnt_q   <= '0;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      mode_q     <= PAR_NONE;
      stop2_q    <= 1'b0;
      par_err_q  <= 1'b0;
      stop_err_q <= 1'b0;
      data_out_q <= '0;
      perr_out_q <= 1'b0;
      serr_out_q <= 1'b0;
      valid_q    <= 1'b0;
      ovr_q      <= 1'b0;
    end else begin
      rx_s1_q    <= RX_data;
      rx_s2_q    <= rx_s1_q;
      rx_prev_q  <= rx_s2_q;
      state_q    <= state_d;
      os_cnt_q   <= os_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      mode_q     <= mode_d;
      stop2_q    <= stop2_d;
      par_err_q  <= par_err_d;
      stop_err_q <= stop_err_d;
      data_out_q <= data_out_d;
      perr_out_q <= perr_out_d;
      serr_out_q <= serr_out_d;
      valid_q    <= valid_d;
      ovr_q      <= ovr_d;
    end
  end

  assign rx_if.rx_valid       = valid_q;
  assign rx_if.RX_data_out    = data_out_q;
  assign rx_if.parity_bit_err = perr_out_q;
  assign rx_if.stop_bit_err   = serr_out_q;
  assign rx_if.overrun_err    = ovr_q;

endmodule

// File: tb/tb_uart_rx_os.sv
// tb_uart_rx_os: directed frames against uart_rx_os with hand-computed
// expected words and flags.
module tb_uart_rx_os;
  localparam int WIDTH = 8;
  localparam int OS    = 16;
  localparam int DIV_W = 16;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [DIV_W-1:0] baud_div = '0;
  logic             parity_en = 1'b0;
  logic             parity_odd = 1'b0;
  logic             two_stop = 1'b0;
  logic             RX_data = 1'b1;

  uart_rx_os_if #(.WIDTH(WIDTH)) rx_if ();

  uart_rx_os #(.WIDTH(WIDTH), .OS(OS), .DIV_W(DIV_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .baud_div   (baud_div),
    .parity_en  (parity_en),
    .parity_odd (parity_odd),
    .two_stop   (two_stop),
    .RX_data    (RX_data),
    .rx_if      (rx_if)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  int bit_t = 16;

  int         frames = 0;
  int         vcyc = 0;
  int         ovr_cyc = 0;
  logic       prev_valid = 1'b0;
  logic [7:0] cap_data = '0;
  logic       cap_perr = 1'b0;
  logic       cap_serr = 1'b0;

  always @(negedge clk) begin
    if (rst) begin
      prev_valid = 1'b0;
    end else begin
      if (rx_if.rx_valid) vcyc++;
      if (rx_if.overrun_err) ovr_cyc++;
      if (rx_if.rx_valid && !prev_valid) begin
        frames++;
        cap_data = rx_if.RX_data_out;
        cap_perr = rx_if.parity_bit_err;
        cap_serr = rx_if.stop_bit_err;
      end
      prev_valid = rx_if.rx_valid;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic bit_out(input logic b);
    RX_data = b;
    repeat (bit_t) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] d, input int par, input logic s1,
                            input logic s2, input int ns);
    bit_out(1'b0);
    for (int i = 0; i < 8; i++) bit_out(d[i]);
    if (par >= 0) bit_out(par[0]);
    bit_out(s1);
    if (ns == 2) bit_out(s2);
    RX_data = 1'b1;
    repeat (2 * bit_t) @(negedge clk);
  endtask

  task automatic check_frame(input string tag, input int fr0, input logic [7:0] d,
                             input logic pe, input logic se);
    check({tag, "_count"}, frames - fr0, 1);
    check({tag, "_data"}, cap_data, d);
    check({tag, "_perr"}, cap_perr, pe);
    check({tag, "_serr"}, cap_serr, se);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int fr0, v0, o0;
    rx_if.rx_ready = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_valid", rx_if.rx_valid, 0);
    check("rst_data", rx_if.RX_data_out, 0);
    check("rst_perr", rx_if.parity_bit_err, 0);
    check("rst_serr", rx_if.stop_bit_err, 0);
    check("rst_ovr", rx_if.overrun_err, 0);

    // 8N1 0x5D, rx_valid should last a single clock with rx_ready high
    fr0 = frames; v0 = vcyc;
    send_frame(8'h5D, -1, 1'b1, 1'b1, 1);
    check_frame("8n1", fr0, 8'h5D, 1'b0, 1'b0);
    check("8n1_vlen", vcyc - v0, 1);

    // slower baud: 32 clocks per bit
    baud_div = 16'd1; bit_t = 32;
    fr0 = frames;
    send_frame(8'hC4, -1, 1'b1, 1'b1, 1);
    check_frame("div1", fr0, 8'hC4, 1'b0, 1'b0);
    baud_div = '0; bit_t = 16;

    // 0x5D has five ones: even parity bit = 1, odd parity bit = 0
    parity_en = 1'b1; parity_odd = 1'b0;
    fr0 = frames;
    send_frame(8'h5D, 0, 1'b1, 1'b1, 1);
    check_frame("8e1_bad", fr0, 8'h5D, 1'b1, 1'b0);
    fr0 = frames;
    send_frame(8'h5D, 1, 1'b1, 1'b1, 1);
    check_frame("8e1_ok", fr0, 8'h5D, 1'b0, 1'b0);
    parity_odd = 1'b1;
    fr0 = frames;
    send_frame(8'h5D, 0, 1'b1, 1'b1, 1);
    check_frame("8o1_ok", fr0, 8'h5D, 1'b0, 1'b0);
    parity_en = 1'b0; parity_odd = 1'b0;

    // start glitch shorter than half a bit
    fr0 = frames;
    RX_data = 1'b0;
    repeat (4) @(negedge clk);
    RX_data = 1'b1;
    repeat (2 * bit_t) @(negedge clk);
    check("glitch_noframe", frames - fr0, 0);
    fr0 = frames;
    send_frame(8'hA3, -1, 1'b1, 1'b1, 1);
    check_frame("after_glitch", fr0, 8'hA3, 1'b0, 1'b0);

    // two stop bits, second one low, then a clean frame clears the flag
    two_stop = 1'b1;
    fr0 = frames;
    send_frame(8'h96, -1, 1'b1, 1'b0, 2);
    check_frame("8n2_bad", fr0, 8'h96, 1'b0, 1'b1);
    fr0 = frames;
    send_frame(8'h69, -1, 1'b1, 1'b1, 2);
    check_frame("8n2_ok", fr0, 8'h69, 1'b0, 1'b0);
    two_stop = 1'b0;

    // break: line low for 12 bit times
    fr0 = frames;
    RX_data = 1'b0;
    repeat (12 * bit_t) @(negedge clk);
    check_frame("break", fr0, 8'h00, 1'b0, 1'b1);
    RX_data = 1'b1;
    repeat (2 * bit_t) @(negedge clk);
    check("break_single", frames - fr0, 1);

    // overrun: second frame dropped while the first is unconsumed
    rx_if.rx_ready = 1'b0;
    fr0 = frames;
    send_frame(8'h11, -1, 1'b1, 1'b1, 1);
    check_frame("ovr_first", fr0, 8'h11, 1'b0, 1'b0);
    o0 = ovr_cyc;
    send_frame(8'h22, -1, 1'b1, 1'b1, 1);
    check("ovr_data", rx_if.RX_data_out, 8'h11);
    check("ovr_valid", rx_if.rx_valid, 1);
    check("ovr_pulse", ovr_cyc - o0, 1);
    check("ovr_noframe", frames - fr0, 1);
    rx_if.rx_ready = 1'b1;
    repeat (2) @(negedge clk);
    check("ovr_drain", rx_if.rx_valid, 0);
    fr0 = frames;
    send_frame(8'h33, -1, 1'b1, 1'b1, 1);
    check_frame("ovr_next", fr0, 8'h33, 1'b0, 1'b0);

    // reset mid-frame with a held word present
    rx_if.rx_ready = 1'b0;
    fr0 = frames;
    send_frame(8'h5A, -1, 1'b1, 1'b1, 1);
    check_frame("pre_rst", fr0, 8'h5A, 1'b0, 1'b0);
    bit_out(1'b0);
    bit_out(1'b0);
    bit_out(1'b1);
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("mrst_valid", rx_if.rx_valid, 0);
    check("mrst_data", rx_if.RX_data_out, 0);
    check("mrst_perr", rx_if.parity_bit_err, 0);
    check("mrst_serr", rx_if.stop_bit_err, 0);
    check("mrst_ovr", rx_if.overrun_err, 0);
    RX_data = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    rx_if.rx_ready = 1'b1;
    fr0 = frames;
    repeat (bit_t) @(negedge clk);
    check("mrst_nopartial", frames - fr0, 0);
    send_frame(8'h7E, -1, 1'b1, 1'b1, 1);
    check_frame("post_rst", fr0, 8'h7E, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/uart_rx_os.md
# uart_rx_os

Oversampling, parametrised UART receiver that converts an asynchronous serial line into parallel words on a valid/ready output. It takes over from the one-bit-per-clock receiver: it adds a programmable baud divider, mid-bit sampling with start-bit glitch rejection, runtime parity and stop-bit modes, and overrun detection. It sits between the pad-side serial input and the receive FIFO or register interface.

## Interface
- WIDTH, 8, data bits per frame, 5..9
- OS, 16, oversample ticks per bit, 8 or 16
- DIV_W, 16, width of baud_div
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- baud_div  in  DIV_W  clocks per oversample tick minus 1
- parity_en  in  1  parity bit present after data
- parity_odd  in  1  1 = odd, 0 = even parity
- two_stop  in  1  two stop bits expected
- RX_data  in  1  serial line, asynchronous, idle high
- rx_ready  in  1  consumer accepts word
- rx_valid  out  1  RX_data_out holds an unconsumed frame
- RX_data_out  out  WIDTH  received word, LSB first on the line
- parity_bit_err  out  1  parity mismatch for the held frame
- stop_bit_err  out  1  a stop bit sampled low for the held frame
- overrun_err  out  1  one-cycle pulse: frame dropped

## Operation
- RX_data passes through a 2-flop synchroniser; both flops reset to 1.
- Tick generator: counter 0..baud_div emits a one-clock tick at terminal count. It is cleared on start-edge detect to align phase.
- States: IDLE, START, DATA, PARITY, STOP1, STOP2, WAIT_HIGH.
- IDLE: on a synchronised 1->0 edge, go to START and clear the tick and sample counters.
- START: after OS/2 ticks, sample the line.
  - Low: go to DATA and latch parity_en, parity_odd and two_stop for this frame.
  - High: go to IDLE (glitch rejection).
- DATA: sample every OS ticks at mid-bit and shift LSB-first. After WIDTH samples, go to PARITY if parity_en, else STOP1.
- PARITY: sample the bit. Expected value is XOR of the data bits, inverted when parity_odd.
- STOP1, and STOP2 when two_stop: sample; any low sample sets the stop error.
- The frame completes at the final stop sample. If the final stop sample was low (break or framing error), go to WAIT_HIGH; otherwise go to IDLE.
- WAIT_HIGH: stay until the synchronised line is 1, then go to IDLE.
- Output register holds one frame:
  - Empty: load data, parity_bit_err and stop_bit_err; set rx_valid.
  - rx_valid && rx_ready at the completion cycle: load the new frame; rx_valid stays 1.
  - rx_valid && !rx_ready: drop the new frame, pulse overrun_err, keep the old word and flags.
- Config input changes mid-frame have no effect until the next START confirmation.

## Timing
- Reset values:
  - State IDLE; all counters 0.
  - rx_valid, parity_bit_err, stop_bit_err, overrun_err: 0.
  - RX_data_out: 0.
- Bit period = (baud_div+1)*OS clocks.
- Start confirmation at (baud_div+1)*OS/2 clocks after the synchronised edge.
- Synchroniser adds 2 clocks from pin to edge detect.
- rx_valid rises the clock after the final stop-bit sample.
- rx_valid falls the clock after rx_valid && rx_ready, unless a frame completes in that same cycle.
- parity_bit_err and stop_bit_err change only when RX_data_out loads.
- A new start edge is accepted in the clock after returning to IDLE.
- Reset mid-frame aborts the frame; no partial word is emitted.

## Structure
- Package uart_pkg holds:
  - The receiver state enum.
  - Parity-mode constants (NONE/EVEN/ODD).
  - OS legality check constants (8/16).
- Sub-module uart_baud_tick (counter, terminal tick, sync clear). It is shared with the future oversampled transmitter.
- Everything else lives in uart_rx_os.

## Test plan
- baud_div=0, OS=16, 8N1, frame 0x5D (line bits 1,0,1,1,1,0,1,0) with rx_ready=1 -> RX_data_out=0x5D, rx_valid for 1 clock, no errors.
- 8E1, 0x5D sent with parity bit 0 -> parity_bit_err=1. The same frame with parity bit 1 -> no error. 8O1 with parity bit 0 -> no error.
- Start pulse low for 4 clocks (under the 8-clock half bit) -> returns to IDLE, no rx_valid, next valid frame 0xA3 received correctly.
- two_stop=1 and second stop bit driven low -> stop_bit_err=1. A break (line low for 12 bit times) -> data 0x00 with stop_bit_err=1, no new frame until the line returns high.
- rx_ready=0, frames 0x11 then 0x22 -> RX_data_out stays 0x11 and overrun_err pulses 1 clock. rx_ready=1 then, followed by frame 0x33 -> 0x33 delivered.
- rst asserted during DATA of a frame, released, then frame 0x7E sent -> outputs at reset values immediately, then 0x7E received with no errors.
